mem_interface: RTL

- Datapath-side responder for the memory field of each microinstruction issued by the control unit.
- Decodes the 3-bit mem_op (FETCH / READ / WRITE), runs one access against the single-port image/program RAM, and returns data to the MBR:
  - opcode byte into mbru, which feeds back to the control unit;
  - pixel byte into mbr_data, which goes to the datapath.
- Every access completes inside the 4-cycle microinstruction window, or the block flags an error.

---
 rtl/mem_interface_pkg.sv | 26 ++
 rtl/mem_interface_if.sv | 24 ++
 rtl/mem_wait_timer.sv | 37 +++
 rtl/mem_interface.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/mem_interface_pkg.sv
// rtl/mem_interface_pkg.sv - shared memory-op codes, FSM encoding and bus width defaults
package mem_interface_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 8;

  typedef enum logic [2:0] {
    MEM_NONE  = 3'b000,
    MEM_WRITE = 3'b001,
    MEM_READ  = 3'b010,
    MEM_FETCH = 3'b100
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } mem_state_e;

  // Only the three one-hot codes start a RAM access.
  function automatic logic is_access_op(input logic [2:0] op);
    return (op == MEM_FETCH) || (op == MEM_READ) || (op == MEM_WRITE);
  endfunction

endpackage

// File: rtl/mem_interface_if.sv
// rtl/mem_interface_if.sv - single-port RAM access bus between mem_interface and the RAM
interface mem_interface_if import mem_interface_pkg::*; #(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) ();

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_en;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ready;

  modport master (
    output ram_addr, ram_wdata, ram_en, ram_we,
    input  ram_rdata, ram_ready
  );

  modport slave (
    input  ram_addr, ram_wdata, ram_en, ram_we,
    output ram_rdata, ram_ready
  );

endinterface

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - saturating WAIT-state timeout counter with load, count and expire
module mem_wait_timer #(
  parameter int TIMEOUT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic count_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (count_i && (cnt_q != CNT_W'(TIMEOUT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Expire on the cycle whose increment would bring the count up to TIMEOUT.
  assign expire_o = count_i && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_interface.sv
// rtl/mem_interface.sv - microinstruction memory-field responder: FETCH/READ/WRITE against the RAM
module mem_interface import mem_interface_pkg::*; #(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int PC_W    = 8,
  parameter int TIMEOUT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mir_strobe_i,
  input  logic [2:0]         mem_op_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [ADDR_W-1:0]  ar_i,
  input  logic [DATA_W-1:0]  dr_in_i,
  input  logic               err_clr_i,
  mem_interface_if.master    ram_if,
  output logic [DATA_W-1:0]  mbru_o,
  output logic [DATA_W-1:0]  mbr_data_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_illegal_o,
  output logic               err_overrun_o,
  output logic               err_timeout_o
);

  mem_state_e        state_q;
  mem_op_e           op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ram_en_q;
  logic              ram_we_q;
  logic [DATA_W-1:0] mbru_q;
  logic [DATA_W-1:0] mbr_data_q;
  logic              busy_q;
  logic              done_q;
  logic              err_illegal_q, err_illegal_d;
  logic              err_overrun_q, err_overrun_d;
  logic              err_timeout_q, err_timeout_d;
  logic              timer_expire;
  logic              illegal_evt, overrun_evt, timeout_evt;

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (state_q == ST_ISSUE),
    .count_i  ((state_q == ST_WAIT) && !ram_if.ram_ready),
    .expire_o (timer_expire)
  );

  // A new error event beats a simultaneous clear.
  always_comb begin
    illegal_evt   = (state_q == ST_IDLE) && mir_strobe_i &&
                    (mem_op_i != MEM_NONE) && !is_access_op(mem_op_i);
    overrun_evt   = (state_q != ST_IDLE) && mir_strobe_i;
    timeout_evt   = (state_q == ST_WAIT) && !ram_if.ram_ready && timer_expire;
    err_illegal_d = illegal_evt || (err_illegal_q && !err_clr_i);
    err_overrun_d = overrun_evt || (err_overrun_q && !err_clr_i);
    err_timeout_d = timeout_evt || (err_timeout_q && !err_clr_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_illegal_q <= 1'b0;
      err_overrun_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      err_illegal_q <= err_illegal_d;
      err_overrun_q <= err_overrun_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= MEM_NONE;
      addr_q     <= '0;
      wdata_q    <= '0;
      ram_en_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      mbru_q     <= '0;
      mbr_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      ram_en_q <= 1'b0;
      ram_we_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mir_strobe_i && is_access_op(mem_op_i)) begin
            op_q     <= mem_op_e'(mem_op_i);
            addr_q   <= (mem_op_i == MEM_FETCH) ? ADDR_W'(pc_i) : ar_i;
            wdata_q  <= dr_in_i;
            ram_en_q <= 1'b1;
            ram_we_q <= (mem_op_i == MEM_WRITE);
            busy_q   <= 1'b1;
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (ram_if.ram_ready) begin
            if (op_q == MEM_FETCH) begin
              mbru_q <= ram_if.ram_rdata;
            end else if (op_q == MEM_READ) begin
              mbr_data_q <= ram_if.ram_rdata;
            end
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else if (timer_expire) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ram_if.ram_addr  = addr_q;
  assign ram_if.ram_wdata = wdata_q;
  assign ram_if.ram_en    = ram_en_q;
  assign ram_if.ram_we    = ram_we_q;
  assign mbru_o           = mbru_q;
  assign mbr_data_o       = mbr_data_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign err_illegal_o    = err_illegal_q;
  assign err_overrun_o    = err_overrun_q;
  assign err_timeout_o    = err_timeout_q;

endmodule
